// File: rtl/stack_pkg.sv
// Shared defaults and word type for the operand stack.
package stack_pkg;

   localparam int STACK_WIDTH = 8;
   localparam int STACK_DEPTH = 16;
   localparam int STACK_PTR_W = $clog2(STACK_DEPTH) + 1;

   typedef logic [STACK_WIDTH-1:0] stack_word_t;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: register file, synchronous write, asynchronous read, no reset.
module stack_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack with registered top-of-stack read.
// Define STACK_UNIT_ERR_EN to build the sticky overflow/underflow flag.
module stack_unit
   import stack_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = STACK_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             tos,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             zero,
   output logic             empty,
   output logic             full,
   output logic             err
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0] sp_q, sp_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] top_data;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    waddr;
   logic             we;

   assign empty   = (sp_q == '0);
   assign full    = (sp_q == PTR_W'(DEPTH));
   assign top_idx = AW'(sp_q - PTR_W'(1));

   // Read happens from pre-edge contents, so tos alongside a write sees the old top.
   always_comb begin
      sp_d   = sp_q;
      dout_d = dout_q;
      we     = 1'b0;
      waddr  = sp_q[AW-1:0];
      if (tos && !empty) begin
         dout_d = top_data;
      end
      if (push && pop && !empty) begin
         we    = 1'b1;
         waddr = top_idx;
      end else if (push && !full) begin
         we   = 1'b1;
         sp_d = sp_q + PTR_W'(1);
      end else if (pop && !push && !empty) begin
         sp_d = sp_q - PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q   <= '0;
         dout_q <= '0;
      end else begin
         sp_q   <= sp_d;
         dout_q <= dout_d;
      end
   end

   stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (we & ~rst),
      .waddr_i (waddr),
      .wdata_i (din),
      .raddr_i (top_idx),
      .rdata_o (top_data)
   );

   assign dout = dout_q;
   assign zero = (dout_q == '0);

`ifdef STACK_UNIT_ERR_EN
   logic err_q, err_d;

   assign err_d = err_q | (push & ~pop & full) | (pop & empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based reference stack predicts outputs per cycle.
module tb_stack_unit;

   localparam int W = 8;
   localparam int D = 16;

`ifdef STACK_UNIT_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] dout;
      logic         empty;
      logic         full;
      logic         err;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         push;
   logic         pop;
   logic         tos;
   logic [W-1:0] din;
   logic [W-1:0] dout;
   logic         zero;
   logic         empty;
   logic         full;
   logic         err;

   logic [W-1:0] model_q [$];
   logic [W-1:0] m_dout;
   logic         m_err;
   exp_t         sb_q [$];
   int           n_checks;
   int           n_fail;

   stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .tos   (tos),
      .din   (din),
      .dout  (dout),
      .zero  (zero),
      .empty (empty),
      .full  (full),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of strobes, advance the model, then compare after the edge.
   task automatic step(input logic p, input logic po, input logic t, input logic r,
                       input logic [W-1:0] d, input string tag);
      exp_t e;
      int   sz;
      push = p; pop = po; tos = t; rst = r; din = d;
      sz = model_q.size();
      if (r) begin
         model_q.delete();
         m_dout = '0;
         m_err  = 1'b0;
      end else begin
         if (t && sz > 0) m_dout = model_q[sz-1];
         if (ERR_EN && ((p && !po && sz == D) || (po && sz == 0))) m_err = 1'b1;
         if (p && po && sz > 0) model_q[sz-1] = d;
         else if (p && sz < D) model_q.push_back(d);
         else if (po && !p && sz > 0) void'(model_q.pop_back());
      end
      e.dout  = m_dout;
      e.empty = (model_q.size() == 0);
      e.full  = (model_q.size() == D);
      e.err   = m_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; tos = 1'b0; rst = 1'b0;
      e = sb_q.pop_front();
      $display("txn %-10s p=%0b po=%0b t=%0b r=%0b din=%02h -> dout=%02h z=%0b e=%0b f=%0b err=%0b",
               tag, p, po, t, r, d, dout, zero, empty, full, err);
      check({tag, ".dout"},  32'(dout),  32'(e.dout));
      check({tag, ".zero"},  32'(zero),  32'(e.dout == '0));
      check({tag, ".empty"}, 32'(empty), 32'(e.empty));
      check({tag, ".full"},  32'(full),  32'(e.full));
      check({tag, ".err"},   32'(err),   32'(e.err));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_dout   = '0;
      m_err    = 1'b0;
      push = 1'b0; pop = 1'b0; tos = 1'b0; rst = 1'b0; din = '0;
      @(posedge clk);
      #1;

      step(0, 0, 0, 1, 8'h00, "reset");
      step(0, 0, 0, 1, 8'h00, "reset2");

      step(1, 0, 0, 0, 8'h05, "push05");
      step(1, 0, 0, 0, 8'h03, "push03");
      step(1, 0, 0, 0, 8'h07, "push07");
      step(0, 0, 1, 0, 8'h00, "tos07");
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h00, "poptos");
      step(0, 1, 0, 0, 8'h00, "pop_empty");

      for (int i = 0; i < D; i++) step(1, 0, 0, 0, 8'(8'h10 + i), "fill");
      step(1, 0, 0, 0, 8'hAA, "push_full");
      step(0, 0, 1, 0, 8'h00, "tos1F");

      step(0, 0, 0, 1, 8'h00, "reset3");
      step(1, 0, 0, 0, 8'h04, "push04");
      step(1, 0, 0, 0, 8'h09, "push09");
      step(1, 1, 0, 0, 8'h00, "replace00");
      step(0, 0, 1, 0, 8'h00, "tos00");
      step(0, 1, 1, 0, 8'h00, "pop00");
      step(0, 1, 1, 0, 8'h00, "pop04");

      step(0, 0, 0, 1, 8'h00, "reset4");
      step(1, 0, 0, 0, 8'h04, "push04");
      step(1, 0, 0, 0, 8'h09, "push09");
      step(1, 0, 1, 0, 8'h22, "tospush22");
      step(0, 0, 1, 0, 8'h00, "tos22");
      step(1, 0, 0, 0, 8'h01, "push01");
      step(1, 0, 0, 0, 8'h02, "push02");
      step(1, 0, 0, 1, 8'h55, "rst_push");
      step(0, 0, 1, 0, 8'h00, "tos_empty");
      step(0, 1, 1, 0, 8'h00, "pop_after");

      for (int i = 0; i < 400; i++) begin
         logic r, p, po, t;
         r  = ($urandom_range(0, 59) == 0);
         p  = ($urandom_range(0, 99) < 55);
         po = ($urandom_range(0, 99) < 40);
         t  = ($urandom_range(0, 99) < 50);
         step(p, po, t, r, 8'($urandom_range(0, 255)), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
